// File: rtl/bootrom_fetch_buffer.sv
// Boot-ROM fetch front end: serves FETCH_WIDTH consecutive instructions per
// request from a synchronous ROM, with a one-line buffer that returns repeated
// fetches of the same address without stalling.
module bootrom_fetch_buffer #(
  parameter int          FETCH_WIDTH = 2,
  parameter int          ROM_WORDS   = 4096,
  parameter int          ROM_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h1fc0_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         read_i,
  input  logic [31:0]                  address_i,
  output logic                         stall_o,
  output logic [32*FETCH_WIDTH-1:0]    data_rd_o,
  output logic [FETCH_WIDTH-1:0]       word_valid_o,
  output logic                         err_o,
  output logic                         rom_en_o,
  output logic [$clog2(ROM_WORDS)-1:0] rom_addr_o,
  input  logic [31:0]                  rom_data_i
);

  localparam int AW  = $clog2(ROM_WORDS);
  localparam int AW1 = AW + 1;
  localparam int CW  = 3;
  localparam logic [CW-1:0]  LAST_SLOT = CW'(FETCH_WIDTH - 1);
  localparam logic [CW-1:0]  NUM_SLOTS = CW'(FETCH_WIDTH);
  localparam logic [AW:0]    ROM_END   = AW1'(ROM_WORDS);
  localparam logic [29:0]    BASE_WORD = BASE_ADDR[31:2];

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  logic [0:0]                        state;
  logic                              buf_valid;
  logic [31:0]                       buf_addr;
  logic                              buf_err;
  logic [FETCH_WIDTH-1:0][31:0]      buf_data;
  logic [FETCH_WIDTH-1:0]            buf_wvalid;
  logic [AW-1:0]                     index0;
  logic [CW-1:0]                     issue_cnt;
  logic [CW-1:0]                     recv_cnt;
  logic [ROM_LATENCY-1:0]            tag_valid;
  logic [ROM_LATENCY-1:0]            tag_inrange;
  logic [ROM_LATENCY-1:0][CW-1:0]    tag_slot;

  logic [29:0] word_off;
  logic        req_err;
  logic        hit;
  logic        issuing;
  logic [AW:0] slot_index;
  logic        slot_inrange;
  logic        tag_out_valid;
  logic        tag_out_inrange;
  logic [CW-1:0] tag_out_slot;

  // Request classification, buffer hit and per-slot issue address.
  always_comb begin
    word_off        = address_i[31:2] - BASE_WORD;
    req_err         = (address_i[1:0] != 2'b00) || (address_i < BASE_ADDR) ||
                      ({2'b00, word_off} >= 32'(ROM_WORDS));
    hit             = read_i && buf_valid && (buf_addr == address_i);
    issuing         = (state == FETCH) && (issue_cnt < NUM_SLOTS);
    slot_index      = {1'b0, index0} + AW1'(issue_cnt);
    slot_inrange    = slot_index < ROM_END;
    tag_out_valid   = tag_valid[ROM_LATENCY-1];
    tag_out_inrange = tag_inrange[ROM_LATENCY-1];
    tag_out_slot    = tag_slot[ROM_LATENCY-1];
  end

  // Bus-facing outputs; everything is forced quiet while reset is held.
  always_comb begin
    stall_o      = 1'b0;
    data_rd_o    = '0;
    word_valid_o = '0;
    err_o        = 1'b0;
    rom_en_o     = 1'b0;
    rom_addr_o   = '0;
    if (!rst) begin
      if (read_i) begin
        if (hit) begin
          data_rd_o    = buf_data;
          word_valid_o = buf_wvalid;
          err_o        = buf_err;
        end else begin
          stall_o = 1'b1;
        end
      end
      if (issuing && slot_inrange) begin
        rom_en_o   = 1'b1;
        rom_addr_o = slot_index[AW-1:0];
      end
    end
  end

  // Return-tag pipeline: follows each issued slot until its ROM data arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid   <= '0;
      tag_inrange <= '0;
      tag_slot    <= '0;
    end else begin
      tag_valid[0]   <= issuing;
      tag_inrange[0] <= issuing && slot_inrange;
      tag_slot[0]    <= issue_cnt;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        tag_valid[i]   <= tag_valid[i-1];
        tag_inrange[i] <= tag_inrange[i-1];
        tag_slot[i]    <= tag_slot[i-1];
      end
    end
  end

  // Control FSM and line buffer fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      buf_valid  <= 1'b0;
      buf_addr   <= '0;
      buf_err    <= 1'b0;
      buf_data   <= '0;
      buf_wvalid <= '0;
      index0     <= '0;
      issue_cnt  <= '0;
      recv_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read_i && !hit) begin
            buf_addr <= address_i;
            if (req_err) begin
              buf_err    <= 1'b1;
              buf_data   <= '0;
              buf_wvalid <= '0;
              buf_valid  <= 1'b1;
            end else begin
              buf_valid <= 1'b0;
              index0    <= word_off[AW-1:0];
              issue_cnt <= '0;
              recv_cnt  <= '0;
              state     <= FETCH;
            end
          end
        end
        default: begin
          if (issuing) begin
            issue_cnt <= issue_cnt + 1'b1;
          end
          if (tag_out_valid) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
              if (tag_out_slot == CW'(k)) begin
                buf_data[k]   <= tag_out_inrange ? rom_data_i : 32'h0;
                buf_wvalid[k] <= tag_out_inrange;
              end
            end
            recv_cnt <= recv_cnt + 1'b1;
            if (recv_cnt == LAST_SLOT) begin
              buf_err   <= 1'b0;
              buf_valid <= 1'b1;
              state     <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bootrom_fetch_buffer.sv
// Scoreboard bench for bootrom_fetch_buffer (FETCH_WIDTH=2, ROM_LATENCY=1).
module tb_bootrom_fetch_buffer;

  localparam int FW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          read_i;
  logic [31:0]   address_i;
  logic          stall_o;
  logic [63:0]   data_rd_o;
  logic [1:0]    word_valid_o;
  logic          err_o;
  logic          rom_en_o;
  logic [11:0]   rom_addr_o;
  logic [31:0]   rom_data_i;
  logic [11:0]   rom_q;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  wv;
    logic        err;
  } exp_t;

  exp_t expQ[$];
  int   romLog[$];
  int   romCycLog[$];
  int   total = 0;
  int   bad = 0;
  int   romCount = 0;
  int   cyc = 0;

  bootrom_fetch_buffer #(
    .FETCH_WIDTH(FW), .ROM_WORDS(4096), .ROM_LATENCY(1), .BASE_ADDR(32'h1fc0_0000)
  ) dut (
    .clk(clk), .rst(rst), .read_i(read_i), .address_i(address_i),
    .stall_o(stall_o), .data_rd_o(data_rd_o), .word_valid_o(word_valid_o),
    .err_o(err_o), .rom_en_o(rom_en_o), .rom_addr_o(rom_addr_o),
    .rom_data_i(rom_data_i)
  );

  always #5 clk = ~clk;

  // ROM model: ROM[i] = A000_0000 + i, one cycle read latency.
  always @(posedge clk) begin
    rom_q <= rom_addr_o;
    cyc   <= cyc + 1;
  end
  assign rom_data_i = 32'hA000_0000 + {20'h0, rom_q};

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: reset/idle cycles must be quiet; every delivered line is scored.
  always @(negedge clk) begin
    exp_t e;
    if (rom_en_o) begin
      romCount++;
      romLog.push_back(int'(rom_addr_o));
      romCycLog.push_back(cyc);
    end
    if (rst) begin
      checkOutput("rst stall", {63'h0, stall_o}, 64'h0);
      checkOutput("rst data", data_rd_o, 64'h0);
      checkOutput("rst wvalid", {62'h0, word_valid_o}, 64'h0);
      checkOutput("rst err", {63'h0, err_o}, 64'h0);
      checkOutput("rst rom_en", {63'h0, rom_en_o}, 64'h0);
    end else if (!read_i) begin
      checkOutput("idle stall", {63'h0, stall_o}, 64'h0);
      checkOutput("idle data", data_rd_o, 64'h0);
      checkOutput("idle wvalid", {62'h0, word_valid_o}, 64'h0);
      checkOutput("idle err", {63'h0, err_o}, 64'h0);
    end else if (!stall_o) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected line actual=%h required=none", data_rd_o);
      end else begin
        e = expQ.pop_front();
        checkOutput("line data", data_rd_o, e.data);
        checkOutput("line wvalid", {62'h0, word_valid_o}, {62'h0, e.wv});
        checkOutput("line err", {63'h0, err_o}, {63'h0, e.err});
      end
    end
  end

  // Issue one request and count its stall cycles until the line is presented.
  task automatic applyStimulus(input string name, input logic [31:0] addr,
                               input logic [63:0] expData, input logic [1:0] expWv,
                               input logic expErr, input int expStalls);
    int  stalls = 0;
    bit  done = 0;
    expQ.push_back('{expData, expWv, expErr});
    read_i    = 1'b1;
    address_i = addr;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (stall_o) stalls++;
      else done = 1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL %s timeout actual=stalled required=data", name);
      if (expQ.size() > 0) void'(expQ.pop_back());
    end
    checkOutput({name, " stalls"}, 64'(stalls), 64'(expStalls));
    @(posedge clk); #1;
  endtask

  task automatic applyIdle(input int n);
    read_i = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    int startCyc;
    int stalls;
    bit done;

    rst = 1'b1;
    read_i = 1'b1;
    address_i = 32'h1fc0_0008;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    applyIdle(1);

    // Miss on 0x1fc0_0008: slots 2,3 issued in cycles 1,2, line in cycle 4.
    c0 = romCount;
    romLog.delete();
    romCycLog.delete();
    startCyc = cyc;
    applyStimulus("miss08", 32'h1fc0_0008, {32'hA000_0003, 32'hA000_0002}, 2'b11, 1'b0, 4);
    checkOutput("miss08 rom pulses", 64'(romCount - c0), 64'd2);
    if (romLog.size() >= 2) begin
      checkOutput("miss08 idx0", 64'(romLog[0]), 64'd2);
      checkOutput("miss08 idx1", 64'(romLog[1]), 64'd3);
      checkOutput("miss08 cyc0", 64'(romCycLog[0] - startCyc), 64'd1);
      checkOutput("miss08 cyc1", 64'(romCycLog[1] - startCyc), 64'd2);
    end

    // Repeated hits, an idle gap, another hit: no stall, no ROM traffic.
    c0 = romCount;
    for (int i = 0; i < 5; i++)
      applyStimulus("hit08", 32'h1fc0_0008, {32'hA000_0003, 32'hA000_0002}, 2'b11, 1'b0, 0);
    applyIdle(1);
    applyStimulus("rehit08", 32'h1fc0_0008, {32'hA000_0003, 32'hA000_0002}, 2'b11, 1'b0, 0);
    checkOutput("hit rom pulses", 64'(romCount - c0), 64'd0);

    // Last ROM word: upper slot falls off the end.
    c0 = romCount;
    romLog.delete();
    applyStimulus("romend", 32'h1fc0_3ffc, {32'h0, 32'hA000_0FFF}, 2'b01, 1'b0, 4);
    checkOutput("romend rom pulses", 64'(romCount - c0), 64'd1);
    if (romLog.size() >= 1) checkOutput("romend idx", 64'(romLog[0]), 64'd4095);

    // Misaligned and below-base requests.
    c0 = romCount;
    applyStimulus("misalign", 32'h1fc0_0002, 64'h0, 2'b00, 1'b1, 1);
    applyStimulus("lowaddr", 32'h0000_0000, 64'h0, 2'b00, 1'b1, 1);
    applyStimulus("beyond", 32'h1fc0_4000, 64'h0, 2'b00, 1'b1, 1);
    checkOutput("err rom pulses", 64'(romCount - c0), 64'd0);

    // Address switched during a fetch: first line completes, then 0x10 misses.
    c0 = romCount;
    romLog.delete();
    expQ.push_back('{{32'hA000_0005, 32'hA000_0004}, 2'b11, 1'b0});
    read_i = 1'b1;
    address_i = 32'h1fc0_0000;
    @(negedge clk);
    checkOutput("switch c0 stall", {63'h0, stall_o}, 64'h1);
    @(posedge clk); #1;
    address_i = 32'h1fc0_0010;
    stalls = 1;
    done = 0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (stall_o) stalls++;
      else done = 1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL switch timeout actual=stalled required=data");
      if (expQ.size() > 0) void'(expQ.pop_back());
    end
    checkOutput("switch stalls", 64'(stalls), 64'd8);
    @(posedge clk); #1;
    checkOutput("switch rom pulses", 64'(romCount - c0), 64'd4);
    if (romLog.size() >= 4) begin
      checkOutput("switch idx2", 64'(romLog[2]), 64'd4);
      checkOutput("switch idx3", 64'(romLog[3]), 64'd5);
    end
    applyIdle(1);

    // Reset in cycle 2 of a miss; the re-request must pay full latency again.
    read_i = 1'b1;
    address_i = 32'h1fc0_0000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput("prerst stall", {63'h0, stall_o}, 64'h1);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus("postrst", 32'h1fc0_0000, {32'hA000_0001, 32'hA000_0000}, 2'b11, 1'b0, 4);
    applyIdle(2);

    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
